// File: rtl/multi_phase_tl_ctrl.sv
// rtl/multi_phase_tl_ctrl.sv - round-robin N-approach traffic light controller
// Optional pedestrian walk phase under `PED_CROSS_EN.
module multi_phase_tl_ctrl #(
  parameter int NUM_PH    = 4,
  parameter int CNT_W     = 8,
  parameter int T_MIN_GRN = 10,
  parameter int T_SHORT   = 20,
  parameter int T_LONG    = 40,
  parameter int T_YEL     = 5,
  parameter int T_ALLRED  = 2,
  parameter int T_STARTUP = 3
`ifdef PED_CROSS_EN
  ,
  parameter int T_WALK    = 8
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef PED_CROSS_EN
  input  logic                      ped_req,
  output logic                      ped_walk,
`endif
  input  logic [NUM_PH-1:0]         car_s1,
  input  logic [NUM_PH-1:0]         car_s2,
  output logic [NUM_PH-1:0]         grn,
  output logic [NUM_PH-1:0]         yel,
  output logic [NUM_PH-1:0]         red,
  output logic [$clog2(NUM_PH)-1:0] cur_ph,
  output logic [1:0]                state_o
);

  localparam int PH_W = $clog2(NUM_PH);

  localparam logic [2:0] ST_ALLRED  = 3'd0;
  localparam logic [2:0] ST_GREEN   = 3'd1;
  localparam logic [2:0] ST_YELLOW  = 3'd2;
  localparam logic [2:0] ST_STARTUP = 3'd3;
  localparam logic [2:0] ST_WALK    = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   MIN_C     = (CNT_W+1)'(T_MIN_GRN);
  localparam logic [CNT_W:0]   SHORT_C   = (CNT_W+1)'(T_SHORT);
  localparam logic [CNT_W:0]   LONG_C    = (CNT_W+1)'(T_LONG);
  localparam logic [CNT_W:0]   YEL_C     = (CNT_W+1)'(T_YEL);
  localparam logic [CNT_W:0]   ALLRED_C  = (CNT_W+1)'(T_ALLRED);
  localparam logic [CNT_W:0]   STARTUP_C = (CNT_W+1)'(T_STARTUP);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [PH_W-1:0]   cur_ph_q, cur_ph_d;
  logic [PH_W-1:0]   nxt_ph_q, nxt_ph_d;
  logic [CNT_W:0]    glim_q, glim_d;
  logic [NUM_PH-1:0] s1_q, s2_q;
  logic [NUM_PH-1:0] grn_q, grn_d, yel_q, yel_d, red_q, red_d;

  logic [CNT_W:0]    tnext;
  logic [NUM_PH-1:0] demand, cur_mask, nxt_mask;
  logic              other_dem, cur_dem, go_veh;
  logic [PH_W-1:0]   rr_ph;
  logic              rr_found;

  assign tnext     = {1'b0, timer_q} + (CNT_W+1)'(1);
  assign demand    = s1_q | s2_q;
  assign cur_mask  = NUM_PH'(1) << cur_ph_q;
  assign nxt_mask  = NUM_PH'(1) << nxt_ph_q;
  assign other_dem = |(demand & ~cur_mask);
  assign cur_dem   = |(demand & cur_mask);
  assign go_veh    = (tnext >= MIN_C) && other_dem && (!cur_dem || tnext >= glim_q);

  // Nearest demanding approach after cur_ph, wrapping around.
  always_comb begin
    int idx;
    rr_ph    = cur_ph_q;
    rr_found = 1'b0;
    for (int i = 1; i < NUM_PH; i++) begin
      idx = (int'(cur_ph_q) + i) % NUM_PH;
      if (!rr_found && |(demand & (NUM_PH'(1) << idx))) begin
        rr_ph    = PH_W'(idx);
        rr_found = 1'b1;
      end
    end
  end

`ifdef PED_CROSS_EN
  logic ped_pend_q, ped_pend_d, walk_pend_q, walk_pend_d, walk_q;
  localparam logic [CNT_W:0] WALK_C = (CNT_W+1)'(T_WALK);
`endif

  always_comb begin
    state_d  = state_q;
    cur_ph_d = cur_ph_q;
    nxt_ph_d = nxt_ph_q;
    glim_d   = glim_q;
`ifdef PED_CROSS_EN
    walk_pend_d = walk_pend_q;
`endif
    case (state_q)
      ST_STARTUP: begin
        if (tnext >= STARTUP_C) begin
          state_d  = ST_GREEN;
          cur_ph_d = '0;
          glim_d   = s2_q[0] ? LONG_C : SHORT_C;
        end
      end
      ST_GREEN: begin
        if (go_veh) begin
          state_d  = ST_YELLOW;
          nxt_ph_d = rr_ph;
        end
`ifdef PED_CROSS_EN
        if (ped_pend_q && tnext >= MIN_C && (go_veh || !other_dem)) begin
          state_d     = ST_YELLOW;
          nxt_ph_d    = other_dem ? rr_ph : cur_ph_q;
          walk_pend_d = 1'b1;
        end
`endif
      end
      ST_YELLOW: begin
        if (tnext >= YEL_C) state_d = ST_ALLRED;
      end
      ST_ALLRED: begin
        if (tnext >= ALLRED_C) begin
          state_d  = ST_GREEN;
          cur_ph_d = nxt_ph_q;
          glim_d   = |(s2_q & nxt_mask) ? LONG_C : SHORT_C;
`ifdef PED_CROSS_EN
          if (walk_pend_q) begin
            state_d     = ST_WALK;
            cur_ph_d    = cur_ph_q;
            glim_d      = glim_q;
            walk_pend_d = 1'b0;
          end
`endif
        end
      end
`ifdef PED_CROSS_EN
      ST_WALK: begin
        if (tnext >= WALK_C) state_d = ST_ALLRED;
      end
`endif
      default: state_d = ST_STARTUP;
    endcase

    if (state_d != state_q)    timer_d = '0;
    else if (timer_q == CNT_MAX) timer_d = timer_q;
    else                       timer_d = tnext[CNT_W-1:0];

    grn_d = (state_d == ST_GREEN)  ? (NUM_PH'(1) << cur_ph_d) : '0;
    yel_d = (state_d == ST_YELLOW) ? (NUM_PH'(1) << cur_ph_d) : '0;
    red_d = ~(grn_d | yel_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_STARTUP;
      timer_q  <= '0;
      cur_ph_q <= '0;
      nxt_ph_q <= '0;
      glim_q   <= SHORT_C;
      s1_q     <= '0;
      s2_q     <= '0;
      grn_q    <= '0;
      yel_q    <= '0;
      red_q    <= '1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cur_ph_q <= cur_ph_d;
      nxt_ph_q <= nxt_ph_d;
      glim_q   <= glim_d;
      s1_q     <= car_s1;
      s2_q     <= car_s2;
      grn_q    <= grn_d;
      yel_q    <= yel_d;
      red_q    <= red_d;
    end
  end

`ifdef PED_CROSS_EN
  // Request is sticky until the walk actually starts.
  always_comb begin
    ped_pend_d = ped_pend_q | ped_req;
    if (state_d == ST_WALK && state_q != ST_WALK) ped_pend_d = ped_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_pend_q  <= 1'b0;
      walk_pend_q <= 1'b0;
      walk_q      <= 1'b0;
    end else begin
      ped_pend_q  <= ped_pend_d;
      walk_pend_q <= walk_pend_d;
      walk_q      <= (state_d == ST_WALK);
    end
  end

  assign ped_walk = walk_q;
`endif

  assign grn     = grn_q;
  assign yel     = yel_q;
  assign red     = red_q;
  assign cur_ph  = cur_ph_q;
  assign state_o = (state_q == ST_WALK) ? 2'b11 : state_q[1:0];

endmodule

// File: tb/tb_multi_phase_tl_ctrl.sv
// tb/tb_multi_phase_tl_ctrl.sv - self-checking bench for multi_phase_tl_ctrl
module tb_multi_phase_tl_ctrl;

  localparam int N      = 4;
  localparam int TMIN   = 10;
  localparam int TSHORT = 20;
  localparam int TLONG  = 40;
  localparam int TYEL   = 5;
  localparam int TAR    = 2;
  localparam int TSU    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] car_s1 = 4'b0000;
  logic [3:0] car_s2 = 4'b0000;
  logic [3:0] grn, yel, red;
  logic [1:0] cur_ph, state_o;

  int n_cmp = 0;
  int n_bad = 0;

  multi_phase_tl_ctrl #(
    .NUM_PH(N), .CNT_W(8), .T_MIN_GRN(TMIN), .T_SHORT(TSHORT), .T_LONG(TLONG),
    .T_YEL(TYEL), .T_ALLRED(TAR), .T_STARTUP(TSU)
  ) dut (
    .clk(clk), .reset(reset), .car_s1(car_s1), .car_s2(car_s2),
    .grn(grn), .yel(yel), .red(red), .cur_ph(cur_ph), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Model: mode 0 all-red, 1 green, 2 yellow, 3 startup; age = cycles spent in mode.
  int         m_mode, m_age, m_ph, m_nxt, m_glim;
  logic [3:0] m_s1q, m_s2q;

  function automatic bit has(input logic [3:0] v, input int i);
    return ((v >> i) & 4'b0001) != 4'b0000;
  endfunction

  task automatic model_reset();
    m_mode = 3; m_age = 0; m_ph = 0; m_nxt = 0; m_glim = TSHORT;
    m_s1q = 4'b0000; m_s2q = 4'b0000;
  endtask

  task automatic model_step(input logic [3:0] s1n, input logic [3:0] s2n);
    logic [3:0] dem;
    int done, prev;
    bit other;
    dem  = m_s1q | m_s2q;
    done = m_age + 1;
    prev = m_mode;
    case (m_mode)
      3: if (done >= TSU) begin
        m_mode = 1; m_ph = 0; m_glim = has(m_s2q, 0) ? TLONG : TSHORT;
      end
      1: begin
        other = 0;
        for (int j = 0; j < N; j++) if (j != m_ph && has(dem, j)) other = 1;
        if (done >= TMIN && other && (!has(dem, m_ph) || done >= m_glim)) begin
          for (int j = N - 1; j >= 1; j--) if (has(dem, (m_ph + j) % N)) m_nxt = (m_ph + j) % N;
          m_mode = 2;
        end
      end
      2: if (done >= TYEL) m_mode = 0;
      default: if (done >= TAR) begin
        m_ph = m_nxt; m_glim = has(m_s2q, m_ph) ? TLONG : TSHORT; m_mode = 1;
      end
    endcase
    m_age = (m_mode != prev) ? 0 : done;
    m_s1q = s1n;
    m_s2q = s2n;
  endtask

  initial begin
    logic [3:0] s1_now, s2_now, e_grn, e_yel, e_red;
    logic       rst_now;
    model_reset();
    forever begin
      @(posedge clk);
      s1_now = car_s1; s2_now = car_s2; rst_now = reset;
      #1;
      if (rst_now) model_reset();
      else model_step(s1_now, s2_now);
      e_grn = (m_mode == 1) ? (4'b0001 << m_ph) : 4'b0000;
      e_yel = (m_mode == 2) ? (4'b0001 << m_ph) : 4'b0000;
      e_red = ~(e_grn | e_yel);
      n_cmp++;
      if (grn !== e_grn || yel !== e_yel || red !== e_red ||
          cur_ph !== 2'(m_ph) || state_o !== 2'(m_mode)) begin
        n_bad++;
        $display("FAIL model t=%0t grn=%b/%b yel=%b/%b red=%b/%b ph=%0d/%0d st=%0d/%0d (actual/required)",
                 $time, grn, e_grn, yel, e_yel, red, e_red, cur_ph, m_ph, state_o, m_mode);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_len(input string name, input logic [3:0] eg, input logic [3:0] ey, input int exp_len);
    int len = 0;
    while (grn === eg && yel === ey && len < 500) begin
      len++;
      tick();
    end
    chk(name, 32'(len), 32'(exp_len));
  endtask

  task automatic startup_checks(input string tag);
    tick(); chk({tag, "_su1_grn"}, 32'(grn), 32'h0); chk({tag, "_su1_st"}, 32'(state_o), 32'h3);
    tick(); chk({tag, "_su2_grn"}, 32'(grn), 32'h0); chk({tag, "_su2_red"}, 32'(red), 32'hf);
    tick(); chk({tag, "_su3_grn"}, 32'(grn), 32'h1); chk({tag, "_su3_st"}, 32'(state_o), 32'h1);
  endtask

  initial begin
    reset = 1'b1;
    tick(); tick();
    chk("rst_red", 32'(red), 32'hf);
    chk("rst_grn", 32'(grn), 32'h0);
    chk("rst_state", 32'(state_o), 32'h3);
    reset = 1'b0;
    startup_checks("a");
    repeat (30) tick();
    chk("rest_grn0", 32'(grn), 32'h1);

    // Only approach 2 waiting: 1 and 3 are skipped.
    car_s1 = 4'b0100;
    tick(); chk("skip_e1_grn", 32'(grn), 32'h1);
    tick(); chk("skip_yel_on", 32'(yel), 32'h1);
    repeat (4) tick(); chk("skip_yel_last", 32'(yel), 32'h1);
    tick(); chk("skip_ar1", 32'(state_o), 32'h0); chk("skip_ar1_red", 32'(red), 32'hf);
    tick(); chk("skip_ar2", 32'(state_o), 32'h0);
    tick(); chk("skip_grn2", 32'(grn), 32'h4); chk("skip_ph2", 32'(cur_ph), 32'h2);

    // Full demand: 20-cycle greens in round-robin order, jam on 1 stretches it to 40.
    car_s1 = 4'b1111;
    run_len("g2", 4'b0100, 4'b0000, TSHORT);
    run_len("y2", 4'b0000, 4'b0100, TYEL);
    run_len("ar23", 4'b0000, 4'b0000, TAR);
    run_len("g3", 4'b1000, 4'b0000, TSHORT);
    car_s2 = 4'b0010;
    run_len("y3", 4'b0000, 4'b1000, TYEL);
    run_len("ar30", 4'b0000, 4'b0000, TAR);
    run_len("g0", 4'b0001, 4'b0000, TSHORT);
    run_len("y0", 4'b0000, 4'b0001, TYEL);
    run_len("ar01", 4'b0000, 4'b0000, TAR);
    run_len("g1_jam", 4'b0010, 4'b0000, TLONG);
    run_len("y1", 4'b0000, 4'b0010, TYEL);
    run_len("ar12", 4'b0000, 4'b0000, TAR);
    run_len("g2b", 4'b0100, 4'b0000, TSHORT);

    // Demand only on 0 and 3, then 3 drops during yellow of 0.
    car_s1 = 4'b1001; car_s2 = 4'b0000;
    run_len("y2b", 4'b0000, 4'b0100, TYEL);
    run_len("ar23b", 4'b0000, 4'b0000, TAR);
    run_len("g3b", 4'b1000, 4'b0000, TSHORT);
    run_len("y3b", 4'b0000, 4'b1000, TYEL);
    run_len("ar30b", 4'b0000, 4'b0000, TAR);
    run_len("g0b", 4'b0001, 4'b0000, TSHORT);
    car_s1 = 4'b0001;
    run_len("y0_drop", 4'b0000, 4'b0001, TYEL);
    run_len("ar03", 4'b0000, 4'b0000, TAR);
    chk("drop_ph3", 32'(cur_ph), 32'h3);
    run_len("g3_min", 4'b1000, 4'b0000, TMIN);

    // Reset in the middle of yellow.
    tick();
    chk("midyel_pre", 32'(yel), 32'h8);
    reset = 1'b1;
    #1;
    chk("async_red", 32'(red), 32'hf);
    chk("async_yel", 32'(yel), 32'h0);
    chk("async_state", 32'(state_o), 32'h3);
    tick();
    reset = 1'b0;
    startup_checks("b");
    repeat (20) tick();
    chk("rest_after", 32'(grn), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
